// File: rtl/game_screen_ctrl.sv
// game_screen_ctrl
//   Screen sequencer for Space Invaders: title -> play -> hit-freeze -> game-over -> title.
//   All timing is counted in VGA frames (rising edges of frame_clk), not in Clk cycles.
//
// Ports
//   Clk, Reset_n     system clock, asynchronous active-low reset
//   frame_clk        VGA vsync in the Clk domain; each rising edge is one frame tick
//   keycode[7:0]     current keyboard keycode (0 = none); START_KEY starts a game
//   player_hit       level, high while a bullet overlaps the player
//   enemies_cleared  level, high while no enemies remain
//   start            title screen active
//   blink            title message visible phase
//   game_active      enemy/player/bullet engines may move
//   player_en        player layer enable (flashes during the hit freeze)
//   game_over        game-over screen active
//   round_reset      one-Clk pulse that re-spawns the wave and clears bullets
//   lives[1:0]       remaining lives
//   level[2:0]       wave number, saturating at 7
module game_screen_ctrl #(
  parameter logic [7:0] START_KEY    = 8'h28,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       player_hit,
  input  logic       enemies_cleared,
  output logic       start,
  output logic       blink,
  output logic       game_active,
  output logic       player_en,
  output logic       game_over,
  output logic       round_reset,
  output logic [1:0] lives,
  output logic [2:0] level
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_OVER  = 3'd3
  } state_t;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     state, state_d;
  logic [7:0] fcnt, fcnt_d;

  logic frame_q, key_q, hit_q, clr_q;
  logic key_match, frame_tick, key_press, hit_rise, clr_rise;

  logic       start_d, blink_d, game_active_d, player_en_d, game_over_d, round_reset_d;
  logic [1:0] lives_d;
  logic [2:0] level_d;

  assign key_match  = (keycode == START_KEY);
  assign frame_tick = frame_clk & ~frame_q;
  assign key_press  = key_match & ~key_q;
  assign hit_rise   = player_hit & ~hit_q;
  assign clr_rise   = enemies_cleared & ~clr_q;

  // Edge registers track their inputs in every state so that a level
  // still high when a state is re-entered does not count as a new event.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      key_q   <= 1'b0;
      hit_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      key_q   <= key_match;
      hit_q   <= player_hit;
      clr_q   <= enemies_cleared;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_TITLE;
      fcnt        <= '0;
      start       <= 1'b1;
      blink       <= 1'b0;
      game_active <= 1'b0;
      player_en   <= 1'b0;
      game_over   <= 1'b0;
      round_reset <= 1'b0;
      lives       <= '0;
      level       <= '0;
    end else begin
      state       <= state_d;
      fcnt        <= fcnt_d;
      start       <= start_d;
      blink       <= blink_d;
      game_active <= game_active_d;
      player_en   <= player_en_d;
      game_over   <= game_over_d;
      round_reset <= round_reset_d;
      lives       <= lives_d;
      level       <= level_d;
    end
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d       = state;
    fcnt_d        = fcnt;
    start_d       = start;
    blink_d       = blink;
    game_active_d = game_active;
    player_en_d   = player_en;
    game_over_d   = game_over;
    round_reset_d = 1'b0;
    lives_d       = lives;
    level_d       = level;

    case (state)
      S_TITLE: begin
        start_d       = 1'b1;
        game_active_d = 1'b0;
        player_en_d   = 1'b0;
        game_over_d   = 1'b0;
        if (key_press) begin
          state_d       = S_PLAY;
          fcnt_d        = '0;
          lives_d       = LIVES_INIT;
          level_d       = '0;
          round_reset_d = 1'b1;
          start_d       = 1'b0;
          blink_d       = 1'b0;
          game_active_d = 1'b1;
          player_en_d   = 1'b1;
        end else if (frame_tick) begin
          if (fcnt == BLINK_LAST) begin
            blink_d = ~blink;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt + 8'd1;
          end
        end
      end

      S_PLAY: begin
        start_d       = 1'b0;
        blink_d       = 1'b0;
        game_active_d = 1'b1;
        player_en_d   = 1'b1;
        game_over_d   = 1'b0;
        // A hit in the same cycle as the wave clearing takes priority.
        if (hit_rise) begin
          fcnt_d        = '0;
          game_active_d = 1'b0;
          player_en_d   = 1'b0;
          if (lives <= 2'd1) begin
            state_d     = S_OVER;
            lives_d     = '0;
            game_over_d = 1'b1;
          end else begin
            state_d = S_HIT;
            lives_d = lives - 2'd1;
          end
        end else begin
          if (clr_rise) begin
            round_reset_d = 1'b1;
            if (level != 3'd7) level_d = level + 3'd1;
          end
          if (frame_tick) fcnt_d = fcnt + 8'd1;
        end
      end

      S_HIT: begin
        start_d       = 1'b0;
        game_active_d = 1'b0;
        game_over_d   = 1'b0;
        if (frame_tick && fcnt == HIT_LAST) begin
          state_d       = S_PLAY;
          fcnt_d        = '0;
          game_active_d = 1'b1;
          player_en_d   = 1'b1;
        end else begin
          if (frame_tick) fcnt_d = fcnt + 8'd1;
          // Registered copy of the frame counter's bit 3: flashes every 8 frames.
          player_en_d = fcnt_d[3];
        end
      end

      S_OVER: begin
        start_d       = 1'b0;
        game_active_d = 1'b0;
        player_en_d   = 1'b0;
        game_over_d   = 1'b1;
        lives_d       = '0;
        if (frame_tick) begin
          if (fcnt == OVER_LAST) begin
            state_d     = S_TITLE;
            fcnt_d      = '0;
            game_over_d = 1'b0;
            start_d     = 1'b1;
            blink_d     = 1'b0;
          end else begin
            fcnt_d = fcnt + 8'd1;
          end
        end
      end

      default: begin
        state_d       = S_TITLE;
        fcnt_d        = '0;
        start_d       = 1'b1;
        blink_d       = 1'b0;
        game_active_d = 1'b0;
        player_en_d   = 1'b0;
        game_over_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_screen_ctrl.sv
module tb_game_screen_ctrl;

  localparam logic [7:0] KEY = 8'h28;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       player_hit;
  logic       enemies_cleared;
  logic       start, blink, game_active, player_en, game_over, round_reset;
  logic [1:0] lives;
  logic [2:0] level;

  game_screen_ctrl #(
    .START_KEY   (KEY),
    .LIVES       (3),
    .BLINK_FRAMES(30),
    .HIT_FRAMES  (60),
    .OVER_FRAMES (180)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .keycode        (keycode),
    .player_hit     (player_hit),
    .enemies_cleared(enemies_cleared),
    .start          (start),
    .blink          (blink),
    .game_active    (game_active),
    .player_en      (player_en),
    .game_over      (game_over),
    .round_reset    (round_reset),
    .lives          (lives),
    .level          (level)
  );

  always #5 Clk = ~Clk;

  // {start, blink, game_active, player_en, game_over, lives, level}
  typedef struct packed {
    logic       start;
    logic       blink;
    logic       act;
    logic       pen;
    logic       over;
    logic [1:0] lives;
    logic [2:0] level;
  } outs_t;

  typedef enum int { OP_FRAMES, OP_KEY, OP_HIT, OP_CLR, OP_BOTH } op_t;

  typedef struct {
    string       name;
    op_t         op;
    int unsigned n;
    outs_t       exp;
    int          rr;
  } vec_t;

  vec_t  tbl[$];
  outs_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    rr_cnt = 0;

  // Counts Clk cycles on which round_reset is high.
  always begin
    @(posedge Clk);
    #1;
    if (round_reset === 1'b1) rr_cnt++;
  end

  function automatic outs_t mk(input logic s, input logic b, input logic a, input logic p,
                               input logic o, input int lv, input int lvl);
    outs_t r;
    r.start = s; r.blink = b; r.act = a; r.pen = p; r.over = o;
    r.lives = 2'(lv); r.level = 3'(lvl);
    return r;
  endfunction

  function automatic void add(input string name, input op_t op, input int unsigned n,
                              input outs_t e, input int rr);
    vec_t v;
    v.name = name; v.op = op; v.n = n; v.exp = e; v.rr = rr;
    tbl.push_back(v);
  endfunction

  task automatic check_pop(input string name);
    outs_t e, a;
    a = {start, blink, game_active, player_en, game_over, lives, level};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: start/blink/act/pen/over/lives/level got %b required %b", name, a, e);
      end
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, a, e);
    end
  endtask

  task automatic run_frames(input int unsigned n);
    repeat (n) begin
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (16) @(negedge Clk);
    end
  endtask

  task automatic pulse_in(input logic h, input logic c);
    @(negedge Clk);
    player_hit = h;
    enemies_cleared = c;
    repeat (2) @(negedge Clk);
    player_hit = 1'b0;
    enemies_cleared = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic hold_key(input int unsigned n);
    @(negedge Clk);
    keycode = KEY;
    repeat (n) @(negedge Clk);
    keycode = 8'h00;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int rr0;

    // Game 1: title blink, start, hit freeze, level saturation, simultaneous last hit, game over.
    add("title_f29",  OP_FRAMES, 29, mk(1,0,0,0,0,0,0), 0);
    add("title_f30",  OP_FRAMES, 1,  mk(1,1,0,0,0,0,0), 0);
    add("title_f59",  OP_FRAMES, 29, mk(1,1,0,0,0,0,0), 0);
    add("title_f60",  OP_FRAMES, 1,  mk(1,0,0,0,0,0,0), 0);
    add("title_f90",  OP_FRAMES, 30, mk(1,1,0,0,0,0,0), 0);
    add("title_f100", OP_FRAMES, 10, mk(1,1,0,0,0,0,0), 0);
    add("key_start",  OP_KEY,    500, mk(0,0,1,1,0,3,0), 1);
    add("hit1",       OP_HIT,    0,  mk(0,0,0,0,0,2,0), 0);
    add("hit_f7",     OP_FRAMES, 7,  mk(0,0,0,0,0,2,0), 0);
    add("hit_f8",     OP_FRAMES, 1,  mk(0,0,0,1,0,2,0), 0);
    add("hit_f15",    OP_FRAMES, 7,  mk(0,0,0,1,0,2,0), 0);
    add("hit_f16",    OP_FRAMES, 1,  mk(0,0,0,0,0,2,0), 0);
    add("hit_clr_ign",OP_CLR,    0,  mk(0,0,0,0,0,2,0), 0);
    add("hit_hit_ign",OP_HIT,    0,  mk(0,0,0,0,0,2,0), 0);
    add("hit_f59",    OP_FRAMES, 43, mk(0,0,0,1,0,2,0), 0);
    add("hit_resume", OP_FRAMES, 1,  mk(0,0,1,1,0,2,0), 0);
    for (int i = 1; i <= 9; i++)
      add($sformatf("clr%0d", i), OP_CLR, 0, mk(0,0,1,1,0,2,(i > 7) ? 7 : i), 1);
    add("play_key_ign", OP_KEY,  50, mk(0,0,1,1,0,2,7), 0);
    add("hit2",       OP_HIT,    0,  mk(0,0,0,0,0,1,7), 0);
    add("hit2_resume",OP_FRAMES, 60, mk(0,0,1,1,0,1,7), 0);
    add("both_last",  OP_BOTH,   0,  mk(0,0,0,0,1,0,7), 0);
    add("over_key_ign", OP_KEY,  50, mk(0,0,0,0,1,0,7), 0);
    add("over_f179",  OP_FRAMES, 179, mk(0,0,0,0,1,0,7), 0);
    add("over_exit",  OP_FRAMES, 1,  mk(1,0,0,0,0,0,7), 0);

    Reset_n = 1'b0;
    frame_clk = 1'b0;
    keycode = 8'h00;
    player_hit = 1'b0;
    enemies_cleared = 1'b0;
    repeat (3) @(negedge Clk);
    exp_q.push_back(mk(1,0,0,0,0,0,0));
    check_pop("reset_values");
    check_int("reset_rr", int'(round_reset), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < tbl.size(); i++) begin
      rr0 = rr_cnt;
      exp_q.push_back(tbl[i].exp);
      case (tbl[i].op)
        OP_FRAMES: run_frames(tbl[i].n);
        OP_KEY:    hold_key(tbl[i].n);
        OP_HIT:    pulse_in(1'b1, 1'b0);
        OP_CLR:    pulse_in(1'b0, 1'b1);
        default:   pulse_in(1'b1, 1'b1);
      endcase
      check_pop(tbl[i].name);
      check_int({tbl[i].name, "_rr"}, rr_cnt - rr0, tbl[i].rr);
    end

    // Game 2: one-cycle start latency and pulse width.
    @(negedge Clk);
    rr0 = rr_cnt;
    keycode = KEY;
    exp_q.push_back(mk(0,0,1,1,0,3,0));
    @(posedge Clk);
    #1;
    check_int("g2_rr_first_cycle", int'(round_reset), 1);
    check_pop("g2_key_latency");
    @(posedge Clk);
    #1;
    check_int("g2_rr_second_cycle", int'(round_reset), 0);
    repeat (20) @(negedge Clk);
    keycode = 8'h00;
    repeat (2) @(negedge Clk);
    check_int("g2_rr_total", rr_cnt - rr0, 1);

    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk(0,0,1,1,0,3,i));
      pulse_in(1'b0, 1'b1);
      check_pop($sformatf("g2_clr%0d", i));
    end

    // Hit and clear together with lives to spare: hit wins, no level bump.
    rr0 = rr_cnt;
    exp_q.push_back(mk(0,0,0,0,0,2,3));
    pulse_in(1'b1, 1'b1);
    check_pop("g2_both_hit");
    check_int("g2_both_rr", rr_cnt - rr0, 0);
    exp_q.push_back(mk(0,0,1,1,0,2,3));
    run_frames(60);
    check_pop("g2_resume");

    // Asynchronous reset mid-play takes effect without a clock edge.
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(1,0,0,0,0,0,0));
    check_pop("async_reset");
    check_int("async_reset_rr", int'(round_reset), 0);

    // Key held through reset yields exactly one press after release.
    keycode = KEY;
    repeat (3) @(negedge Clk);
    rr0 = rr_cnt;
    Reset_n = 1'b1;
    exp_q.push_back(mk(0,0,1,1,0,3,0));
    @(posedge Clk);
    #1;
    check_int("held_key_rr", int'(round_reset), 1);
    check_pop("held_key_press");
    repeat (30) @(negedge Clk);
    keycode = 8'h00;
    repeat (2) @(negedge Clk);
    check_int("held_key_rr_total", rr_cnt - rr0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
